// File: rtl/encoder64_6.sv
// rtl/encoder64_6.sv - 64-to-6 sequential priority encoder with request buffering
// Requests accumulate in a pending vector; indices drain lowest-first via valid/ready.
module encoder64_6 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [63:0] req,
  input  logic        ready,
  output logic [5:0]  A,
  output logic        valid,
  output logic [63:0] pending,
  output logic [6:0]  count
);

  logic [63:0] r_p;
  logic        r_valid;
  logic [5:0]  r_a;
  logic [6:0]  r_count;

  logic        w_load;
  logic        w_p_nz;
  logic [5:0]  w_idx;
  logic [63:0] w_pop_mask;
  logic [63:0] w_p_next;
  logic [6:0]  w_cnt_next;

  assign w_load = !r_valid || ready;
  assign w_p_nz = |r_p;

  // Lowest set bit wins: scan downward so the last hit is the smallest index.
  always_comb begin
    w_idx = 6'd0;
    for (int i = 63; i >= 0; i--) begin
      if (r_p[i]) w_idx = 6'(i);
    end
  end

  // Pop before merge so a re-request of the popped index in the same cycle survives.
  always_comb begin
    w_pop_mask = 64'd0;
    if (w_load && w_p_nz) w_pop_mask = 64'd1 << w_idx;
    w_p_next = (r_p & ~w_pop_mask) | (en ? req : 64'd0);
  end

  always_comb begin
    w_cnt_next = 7'd0;
    for (int i = 0; i < 64; i++) begin
      w_cnt_next = w_cnt_next + 7'(w_p_next[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p     <= 64'd0;
      r_valid <= 1'b0;
      r_a     <= 6'd0;
      r_count <= 7'd0;
    end else begin
      r_p     <= w_p_next;
      r_count <= w_cnt_next;
      if (w_load) begin
        r_valid <= w_p_nz;
        if (w_p_nz) r_a <= w_idx;
      end
    end
  end

  assign A       = r_a;
  assign valid   = r_valid;
  assign pending = r_p;
  assign count   = r_count;

endmodule

// File: tb/tb_encoder64_6.sv
// tb/tb_encoder64_6.sv - self-checking bench for encoder64_6
// Expected indices are queued as stimulus is applied and popped on each handshake.
module tb_encoder64_6;

  logic        clk;
  logic        rst;
  logic        en;
  logic [63:0] req;
  logic        ready;
  logic [5:0]  A;
  logic        valid;
  logic [63:0] pending;
  logic [6:0]  count;

  int n_checks;
  int n_fail;
  logic [5:0] exp_q[$];

  encoder64_6 dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .ready   (ready),
    .A       (A),
    .valid   (valid),
    .pending (pending),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: a handshake seen before the edge pops the scoreboard; sample #1 after.
  task automatic tick();
    logic       hs;
    logic [5:0] a;
    hs = valid && ready && !rst;
    a  = A;
    @(posedge clk);
    #1;
    if (hs) begin
      if (exp_q.size() == 0) begin
        chk("sb_extra_output", 64'(exp_q.size()), 64'd1);
      end else begin
        chk("sb_index", 64'(a), 64'(exp_q.pop_front()));
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst   = 1'b1;
    en    = 1'b0;
    req   = 64'd0;
    ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_pending", pending, 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_a", 64'(A), 64'd0);

    // Single request: 2-cycle latency, drop after accept
    en = 1'b1; ready = 1'b1; req = 64'h1;
    exp_q.push_back(6'd0);
    tick();
    req = 64'd0;
    chk("t1_e0_valid", 64'(valid), 64'd0);
    chk("t1_e0_count", 64'(count), 64'd1);
    tick();
    chk("t1_e1_valid", 64'(valid), 64'd1);
    chk("t1_e1_a", 64'(A), 64'd0);
    chk("t1_e1_count", 64'(count), 64'd0);
    tick();
    chk("t1_e2_valid", 64'(valid), 64'd0);
    chk("t1_e2_count", 64'(count), 64'd0);

    // Multi-hot with backpressure
    ready = 1'b0; req = 64'h8000_0000_0000_0011;
    tick();
    req = 64'd0;
    chk("t2_e0_count", 64'(count), 64'd3);
    tick();
    chk("t2_valid", 64'(valid), 64'd1);
    chk("t2_a", 64'(A), 64'd0);
    chk("t2_pending", pending, 64'h8000_0000_0000_0010);
    chk("t2_count", 64'(count), 64'd2);
    req = 64'h10;
    tick();
    req = 64'd0;
    chk("t2_hold_a", 64'(A), 64'd0);
    chk("t2_merge_count", 64'(count), 64'd2);
    exp_q.push_back(6'd0);
    exp_q.push_back(6'd4);
    exp_q.push_back(6'd63);
    ready = 1'b1;
    tick();
    chk("t2_a4", 64'(A), 64'd4);
    chk("t2_c1", 64'(count), 64'd1);
    tick();
    chk("t2_a63", 64'(A), 64'd63);
    chk("t2_c0", 64'(count), 64'd0);
    tick();
    chk("t2_drop", 64'(valid), 64'd0);
    chk("t2_sb_empty", 64'(exp_q.size()), 64'd0);

    // All 64 requests drain without bubbles
    req = '1;
    tick();
    req = 64'd0;
    chk("t3_count64", 64'(count), 64'd64);
    for (int k = 0; k < 64; k++) exp_q.push_back(6'(k));
    for (int k = 0; k < 64; k++) begin
      tick();
      chk("t3_valid", 64'(valid), 64'd1);
      chk("t3_count", 64'(count), 64'(63 - k));
    end
    tick();
    chk("t3_drop", 64'(valid), 64'd0);
    chk("t3_sb_empty", 64'(exp_q.size()), 64'd0);

    // Set wins over pop of the same bit
    req = 64'h20;
    exp_q.push_back(6'd5);
    exp_q.push_back(6'd5);
    tick();
    tick();
    req = 64'd0;
    chk("t4_first_a", 64'(A), 64'd5);
    chk("t4_setwins_count", 64'(count), 64'd1);
    tick();
    chk("t4_again_a", 64'(A), 64'd5);
    chk("t4_again_valid", 64'(valid), 64'd1);
    chk("t4_again_count", 64'(count), 64'd0);
    tick();
    chk("t4_drop", 64'(valid), 64'd0);

    // Capture disabled
    en = 1'b0; req = 64'hFFFF;
    tick();
    tick();
    chk("t5_pending", pending, 64'd0);
    chk("t5_valid", 64'(valid), 64'd0);
    chk("t5_count", 64'(count), 64'd0);

    // Reset mid-stream
    en = 1'b1; ready = 1'b0; req = 64'h7FF;
    tick();
    req = 64'd0;
    tick();
    chk("t6_pre_count", 64'(count), 64'd10);
    chk("t6_pre_valid", 64'(valid), 64'd1);
    rst = 1'b1; req = '1;
    tick();
    rst = 1'b0; req = 64'd0; ready = 1'b1;
    chk("t6_valid", 64'(valid), 64'd0);
    chk("t6_pending", pending, 64'd0);
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_a", 64'(A), 64'd0);
    tick();
    tick();
    chk("t6_no_stale", 64'(valid), 64'd0);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
